// File: rtl/led_fade_sequencer_pkg.sv
// Shared types, defaults and saturating arithmetic for the LED fade sequencer
// and the other blocks on the PWM duty path.
package led_fade_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_MANUAL  = 3'd0,
    ST_UP      = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_DOWN    = 3'd3,
    ST_HOLD_LO = 3'd4
  } fade_state_e;

  localparam int DEF_CLOCK_FREQ_MHZ = 100;
  localparam int DEF_PWM_VALUE_SIZE = 8;
  localparam int DEF_STEP_PERIOD_US = 2000;

  localparam int MAX_VALUE   = (1 << DEF_PWM_VALUE_SIZE) - 1;
  localparam int TICK_CYCLES = DEF_CLOCK_FREQ_MHZ * DEF_STEP_PERIOD_US;

  // Wide enough for W+1-bit arithmetic on any duty width up to 16 bits.
  localparam int SAT_W = 17;

  function automatic int calc_max_value(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int calc_tick_cycles(input int freq_mhz, input int period_us);
    return freq_mhz * period_us;
  endfunction

  // Add or subtract step, clamped to [floor_v, cap_v]; operands stay below 2**16
  // so neither val+step nor floor_v+step can overflow SAT_W bits.
  function automatic logic [SAT_W-1:0] sat_step(
    input logic [SAT_W-1:0] val,
    input logic [SAT_W-1:0] step,
    input logic [SAT_W-1:0] floor_v,
    input logic [SAT_W-1:0] cap_v,
    input logic             sub
  );
    if (sub) begin
      return (val >= floor_v + step) ? val - step : floor_v;
    end
    return (val + step >= cap_v) ? cap_v : val + step;
  endfunction

endpackage

// File: rtl/led_fade_sequencer_if.sv
// Encoder-side pulses in, PWM duty value and debug status out.
interface led_fade_sequencer_if #(
  parameter int W = led_fade_sequencer_pkg::DEF_PWM_VALUE_SIZE
);
  logic         increase_i;
  logic         decrease_i;
  logic         mode_toggle_i;
  logic [W-1:0] value_o;
  logic         mode_o;
  logic [2:0]   state_o;

  modport master (
    output increase_i, decrease_i, mode_toggle_i,
    input  value_o, mode_o, state_o
  );

  modport slave (
    input  increase_i, decrease_i, mode_toggle_i,
    output value_o, mode_o, state_o
  );
endinterface

// File: rtl/led_fade_sequencer_step_tick_gen.sv
// Fade step prescaler: one-cycle tick every CYCLES_PER_TICK enabled cycles,
// counter held at zero while disabled.
module step_tick_gen
  import led_fade_sequencer_pkg::*;
#(
  parameter int CYCLES_PER_TICK = TICK_CYCLES
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CYCLES_PER_TICK > 1) ? $clog2(CYCLES_PER_TICK) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(CYCLES_PER_TICK - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
    end else if (!en_i || r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick_o = en_i && (r_cnt == C_LAST);

endmodule

// File: rtl/led_fade_sequencer.sv
// Brightness sequencer between the encoder decoder and the PWM generator:
// manual stepping or an automatic up/hold/down/hold breathe cycle.
module led_fade_sequencer
  import led_fade_sequencer_pkg::*;
#(
  parameter int CLOCK_FREQ_MHZ = DEF_CLOCK_FREQ_MHZ,
  parameter int PWM_VALUE_SIZE = DEF_PWM_VALUE_SIZE,
  parameter int BRIGHTNESS_INC = 5,
  parameter int STEP_PERIOD_US = DEF_STEP_PERIOD_US,
  parameter int HOLD_STEPS     = 50
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  led_fade_sequencer_if.slave io_bus
);

  localparam int W      = PWM_VALUE_SIZE;
  localparam int MAX_V  = calc_max_value(PWM_VALUE_SIZE);
  localparam int TICK_N = calc_tick_cycles(CLOCK_FREQ_MHZ, STEP_PERIOD_US);
  localparam int HCW    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [SAT_W-1:0] C_INC  = SAT_W'(BRIGHTNESS_INC);
  localparam logic [SAT_W-1:0] C_MAX  = SAT_W'(MAX_V);
  localparam logic [SAT_W-1:0] C_ZERO = '0;
  localparam logic [W-1:0]     V_MAX  = W'(MAX_V);
  localparam logic [HCW-1:0]   H_LAST = HCW'(HOLD_STEPS - 1);

  fade_state_e    r_state;
  logic [W-1:0]   r_value;
  logic [W-1:0]   r_peak;
  logic           r_mode;
  logic [HCW-1:0] r_hold;

  logic         w_inc, w_dec, w_tog, w_adjust;
  logic         w_tick, w_tick_en, w_hold_last;
  logic [W-1:0] w_man_val, w_peak_adj, w_val_clamp, w_up_val, w_down_val;

  assign w_inc    = io_bus.increase_i;
  assign w_dec    = io_bus.decrease_i;
  assign w_tog    = io_bus.mode_toggle_i;
  assign w_adjust = w_inc ^ w_dec;

  // A toggle in either direction leaves the prescaler at zero, so the first tick
  // after entering BREATHE lands a full period later.
  assign w_tick_en = r_mode & ~w_tog;

  step_tick_gen #(
    .CYCLES_PER_TICK(TICK_N)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en_i   (w_tick_en),
    .tick_o (w_tick)
  );

  assign w_man_val  = W'(sat_step(SAT_W'(r_value), C_INC, C_ZERO, C_MAX, w_dec));
  assign w_peak_adj = w_adjust ? W'(sat_step(SAT_W'(r_peak), C_INC, C_INC, C_MAX, w_dec))
                               : r_peak;
  // A lowered peak pulls the rising/high value down with it in the same update.
  assign w_val_clamp = (r_value > w_peak_adj) ? w_peak_adj : r_value;
  assign w_up_val    = w_tick ? W'(sat_step(SAT_W'(w_val_clamp), C_INC, C_ZERO,
                                            SAT_W'(w_peak_adj), 1'b0))
                              : w_val_clamp;
  assign w_down_val  = W'(sat_step(SAT_W'(r_value), C_INC, C_ZERO, C_MAX, 1'b1));
  assign w_hold_last = (r_hold == H_LAST);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_MANUAL;
      r_value <= '0;
      r_peak  <= '0;
      r_mode  <= 1'b0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        ST_MANUAL: begin
          if (w_tog) begin
            r_peak  <= (r_value == '0) ? V_MAX : r_value;
            r_value <= '0;
            r_mode  <= 1'b1;
            r_state <= ST_UP;
            r_hold  <= '0;
          end else if (w_adjust) begin
            r_value <= w_man_val;
          end
        end
        ST_UP, ST_HOLD_HI, ST_DOWN, ST_HOLD_LO: begin
          if (w_tog) begin
            r_value <= r_peak;
            r_mode  <= 1'b0;
            r_state <= ST_MANUAL;
            r_hold  <= '0;
          end else begin
            r_peak <= w_peak_adj;
            case (r_state)
              ST_UP: begin
                r_value <= w_up_val;
                if (w_up_val == w_peak_adj) begin
                  r_state <= ST_HOLD_HI;
                  r_hold  <= '0;
                end
              end
              ST_HOLD_HI: begin
                r_value <= w_val_clamp;
                if (w_tick) begin
                  r_hold <= w_hold_last ? '0 : r_hold + HCW'(1);
                  if (w_hold_last) r_state <= ST_DOWN;
                end
              end
              ST_DOWN: begin
                if (w_tick) begin
                  r_value <= w_down_val;
                  if (w_down_val == '0) begin
                    r_state <= ST_HOLD_LO;
                    r_hold  <= '0;
                  end
                end
              end
              default: begin
                if (w_tick) begin
                  r_hold <= w_hold_last ? '0 : r_hold + HCW'(1);
                  if (w_hold_last) r_state <= ST_UP;
                end
              end
            endcase
          end
        end
        default: begin
          r_state <= ST_MANUAL;
          r_mode  <= 1'b0;
          r_value <= '0;
          r_hold  <= '0;
        end
      endcase
    end
  end

  assign io_bus.value_o = r_value;
  assign io_bus.mode_o  = r_mode;
  assign io_bus.state_o = r_state;

endmodule

// File: tb/tb_led_fade_sequencer.sv
// Randomized and directed bench for led_fade_sequencer against a behavioural
// model built from the brightness/fade rules with plain integer arithmetic.
module tb_led_fade_sequencer;

  localparam int W    = 8;
  localparam int INC  = 5;
  localparam int TICK = 4;
  localparam int HOLD = 2;
  localparam int MAXV = 255;
  localparam int P_MANUAL = 0, P_UP = 1, P_HOLD_HI = 2, P_DOWN = 3, P_HOLD_LO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_value, m_peak, m_mode, m_phase, m_since, m_hold;

  led_fade_sequencer_if #(.W(W)) bus ();

  led_fade_sequencer #(
    .CLOCK_FREQ_MHZ(1),
    .PWM_VALUE_SIZE(W),
    .BRIGHTNESS_INC(INC),
    .STEP_PERIOD_US(4),
    .HOLD_STEPS    (HOLD)
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, ".value"}, int'(bus.value_o), m_value);
    check_eq({tag, ".mode"},  int'(bus.mode_o),  m_mode);
    check_eq({tag, ".state"}, int'(bus.state_o), m_phase);
  endtask

  task automatic model_reset();
    m_value = 0; m_peak = 0; m_mode = 0; m_phase = P_MANUAL; m_since = 0; m_hold = 0;
  endtask

  // Expected outputs after one clock edge with the given pulses applied.
  task automatic model_step(input bit inc, input bit dec, input bit tog);
    bit tick;
    if (m_mode == 0) begin
      if (tog) begin
        m_peak  = (m_value == 0) ? MAXV : m_value;
        m_value = 0; m_mode = 1; m_phase = P_UP; m_since = 0; m_hold = 0;
      end else if (inc && !dec) begin
        m_value = imin(m_value + INC, MAXV);
      end else if (dec && !inc) begin
        m_value = imax(m_value - INC, 0);
      end
    end else if (tog) begin
      m_value = m_peak; m_mode = 0; m_phase = P_MANUAL;
    end else begin
      m_since++;
      tick = (m_since % TICK) == 0;
      if (inc && !dec) m_peak = imin(m_peak + INC, MAXV);
      if (dec && !inc) m_peak = imax(m_peak - INC, INC);
      if ((m_phase == P_UP || m_phase == P_HOLD_HI) && m_value > m_peak) m_value = m_peak;
      case (m_phase)
        P_UP: begin
          if (tick) m_value = imin(m_value + INC, m_peak);
          if (m_value == m_peak) begin m_phase = P_HOLD_HI; m_hold = 0; end
        end
        P_HOLD_HI: if (tick) begin
          m_hold++;
          if (m_hold == HOLD) m_phase = P_DOWN;
        end
        P_DOWN: if (tick) begin
          m_value = imax(m_value - INC, 0);
          if (m_value == 0) begin m_phase = P_HOLD_LO; m_hold = 0; end
        end
        default: if (tick) begin
          m_hold++;
          if (m_hold == HOLD) begin m_phase = P_UP; m_hold = 0; end
        end
      endcase
    end
  endtask

  // Called at a falling edge; returns at the next falling edge with outputs checked.
  task automatic do_cycle(input bit inc, input bit dec, input bit tog, input string tag);
    bus.increase_i    = inc;
    bus.decrease_i    = dec;
    bus.mode_toggle_i = tog;
    model_step(inc, dec, tog);
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
    if (inc || dec || tog)
      $display("txn %s t=%0t inc=%0b dec=%0b tog=%0b -> value=%0d mode=%0d state=%0d",
               tag, $time, inc, dec, tog, bus.value_o, bus.mode_o, bus.state_o);
  endtask

  task automatic async_reset(input string tag);
    bus.increase_i = 1'b0; bus.decrease_i = 1'b0; bus.mode_toggle_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs({tag, ".released"});
  endtask

  initial begin
    bus.increase_i = 1'b0; bus.decrease_i = 1'b0; bus.mode_toggle_i = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset_hold");
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("reset_release");

    for (int i = 1; i <= 52; i++) begin
      do_cycle(1, 0, 0, $sformatf("man_inc%0d", i));
      if (i >= 51) check_eq($sformatf("man_sat_hi%0d", i), int'(bus.value_o), 255);
    end
    do_cycle(1, 1, 0, "man_both");
    check_eq("man_both_const", int'(bus.value_o), 255);
    for (int i = 1; i <= 52; i++) do_cycle(0, 1, 0, $sformatf("man_dec%0d", i));
    check_eq("man_sat_lo", int'(bus.value_o), 0);

    do_cycle(1, 0, 0, "s3_inc_a");
    do_cycle(1, 0, 0, "s3_inc_b");
    do_cycle(0, 0, 1, "s3_toggle");
    check_eq("s3_enter_value", int'(bus.value_o), 0);
    check_eq("s3_enter_mode", int'(bus.mode_o), 1);
    for (int i = 1; i <= 50; i++) begin
      do_cycle(0, 0, 0, $sformatf("s3_idle%0d", i));
      case (i)
        3:  check_eq("s3_e3_value", int'(bus.value_o), 0);
        4:  check_eq("s3_e4_value", int'(bus.value_o), 5);
        8:  check_eq("s3_e8_state", int'(bus.state_o), 2);
        15: check_eq("s3_e15_state", int'(bus.state_o), 2);
        16: check_eq("s3_e16_state", int'(bus.state_o), 3);
        20: check_eq("s3_e20_value", int'(bus.value_o), 5);
        24: check_eq("s3_e24_state", int'(bus.state_o), 4);
        31: check_eq("s3_e31_state", int'(bus.state_o), 4);
        32: check_eq("s3_e32_state", int'(bus.state_o), 1);
        36: check_eq("s3_e36_value", int'(bus.value_o), 5);
        default: ;
      endcase
    end
    check_eq("s1_mid_down_state", int'(bus.state_o), 3);
    async_reset("s1_mid_down");

    do_cycle(0, 0, 1, "s4_toggle_zero");
    for (int i = 1; i <= 210; i++) begin
      do_cycle(0, 0, 0, $sformatf("s4_idle%0d", i));
      if (i == 203) check_eq("s4_e203_value", int'(bus.value_o), 250);
      if (i == 204) check_eq("s4_e204_value", int'(bus.value_o), 255);
      if (i == 204) check_eq("s4_e204_state", int'(bus.state_o), 2);
    end

    async_reset("s5_prep");
    for (int i = 1; i <= 4; i++) do_cycle(1, 0, 0, $sformatf("s5_inc%0d", i));
    do_cycle(0, 0, 1, "s5_toggle");
    for (int i = 1; i <= 16; i++) do_cycle(0, 0, 0, $sformatf("s5_idle%0d", i));
    check_eq("s5_hold_value", int'(bus.value_o), 20);
    check_eq("s5_hold_state", int'(bus.state_o), 2);
    do_cycle(0, 1, 0, "s5_dec1");
    check_eq("s5_clamp_value", int'(bus.value_o), 15);
    for (int i = 2; i <= 5; i++) do_cycle(0, 1, 0, $sformatf("s5_dec%0d", i));
    check_eq("s5_floor_value", int'(bus.value_o), 5);
    do_cycle(0, 0, 1, "s5_to_manual");
    check_eq("s5_floor_peak", int'(bus.value_o), 5);

    do_cycle(0, 0, 1, "s6_toggle");
    do_cycle(1, 0, 0, "s6_inc_a");
    do_cycle(1, 0, 0, "s6_inc_b");
    do_cycle(0, 0, 0, "s6_idle_a");
    do_cycle(0, 0, 0, "s6_idle_b");
    check_eq("s6_tick_value", int'(bus.value_o), 5);
    do_cycle(1, 0, 1, "s6_tog_inc");
    check_eq("s6_exit_value", int'(bus.value_o), 15);
    check_eq("s6_exit_mode", int'(bus.mode_o), 0);
    for (int i = 1; i <= 3; i++) do_cycle(0, 0, 0, $sformatf("s6_man_idle%0d", i));
    do_cycle(0, 0, 1, "s6_reenter");
    for (int i = 1; i <= 4; i++) do_cycle(0, 0, 0, $sformatf("s6_re_idle%0d", i));
    check_eq("s6_first_tick_value", int'(bus.value_o), 5);

    for (int i = 0; i < 3000; i++) begin
      bit inc, dec, tog;
      inc = ($urandom_range(0, 19) == 0);
      dec = ($urandom_range(0, 19) == 0);
      tog = ($urandom_range(0, 199) == 0);
      do_cycle(inc, dec, tog, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
